instr_prefetch_buffer: RTL and testbench

Parametrised instruction prefetch stage for the RV32IC pipeline, replacing the fixed three-entry fetch FIFO. It keeps up to `MAX_OUTSTANDING` bus requests in flight and buffers responses in a `DEPTH`-entry FIFO. It realigns 16/32-bit instructions across word boundaries and hands the decoder one instruction per cycle through a valid/ready handshake. It sits between the instruction memory port and decode; branch, jump and trap redirects flush it.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/instr_fifo.sv | 60 ++++++
 rtl/instr_prefetch_buffer.sv | 160 ++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } fetch_entry_t;

  function automatic logic is_compressed(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular response buffer with head and head+1 read ports for the aligner.
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  fetch_entry_t     i_entry,
  input  logic             i_pop,
  input  logic             i_clear,
  output fetch_entry_t     o_head,
  output fetch_entry_t     o_next,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full buffer is only legal alongside a pop; the slot being
  // written is the one the head pointer is leaving.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_entry;
        r_wr        <= wrap_inc(r_wr);
      end
      if (i_pop) begin
        r_rd <= wrap_inc(r_rd);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_next  = r_mem[wrap_inc(r_rd)];
  assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// RV32IC prefetch stage: bounded outstanding bus requests, response FIFO,
// and a halfword aligner presenting one instruction per cycle to decode.
module instr_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET        = 32'h0,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_compressed_o,
  output logic        instr_err_o
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH + 2);

  logic             r_active;
  logic             r_hold;
  logic             r_stale;
  logic [31:0]      r_stale_addr;
  logic [31:0]      r_fetch_addr;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_outst;
  logic [CNT_W-1:0] r_discard;

  logic [OCC_W-1:0] w_occ;
  fetch_entry_t     w_head;
  fetch_entry_t     w_next;
  fetch_entry_t     w_entry;
  logic             w_room;
  logic             w_fire;
  logic             w_push;
  logic             w_pop;
  logic [15:0]      w_half;
  logic             w_comp;
  logic             w_span;
  logic             w_valid;
  logic             w_err;
  logic             w_retire;
  logic [31:0]      w_instr;

  // ---------------------------------------------------------------- requests
  assign w_room = (32'(w_occ) + 32'(r_outst) < DEPTH) &&
                  (32'(r_outst) < MAX_OUTSTANDING);
  assign instr_req_o  = r_active && (r_hold || w_room);
  assign instr_addr_o = r_stale ? r_stale_addr : r_fetch_addr;
  assign w_fire       = instr_req_o && instr_gnt_i;

  // A request caught by a redirect before its grant keeps its old address in
  // r_stale_addr; fetch_addr already points at the new stream meanwhile.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active     <= 1'b0;
      r_hold       <= 1'b0;
      r_stale      <= 1'b0;
      r_stale_addr <= '0;
      r_fetch_addr <= PC_RESET & ~32'h3;
    end else begin
      r_active <= 1'b1;
      r_hold   <= instr_req_o && !instr_gnt_i;
      if (redirect_i && instr_req_o && !instr_gnt_i) begin
        r_stale      <= 1'b1;
        r_stale_addr <= instr_addr_o;
      end else if (w_fire) begin
        r_stale <= 1'b0;
      end
      if (redirect_i) begin
        r_fetch_addr <= {redirect_pc_i[31:2], 2'b00};
      end else if (w_fire && !r_stale) begin
        r_fetch_addr <= r_fetch_addr + 32'(INSTR_WORD_BYTES);
      end
    end
  end

  // ------------------------------------------------ outstanding and discards
  // On redirect every old-stream response still to come is dropped: those in
  // flight, the one being requested now, minus any arriving this cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_outst   <= '0;
      r_discard <= '0;
    end else begin
      r_outst <= r_outst + CNT_W'(w_fire) - CNT_W'(instr_rvalid_i);
      if (redirect_i) begin
        r_discard <= r_outst + CNT_W'(instr_req_o) - CNT_W'(instr_rvalid_i);
      end else if (instr_rvalid_i && (r_discard != '0)) begin
        r_discard <= r_discard - CNT_W'(1);
      end
    end
  end

  assign w_entry = '{rdata: instr_rdata_i, err: instr_err_i};
  assign w_push  = instr_rvalid_i && !redirect_i && (r_discard == '0);

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_clear (redirect_i),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_count (w_occ)
  );

  // ----------------------------------------------------------------- aligner
  // An errored head word is presented as a complete 32-bit instruction so the
  // fault reaches decode without waiting for the following word.
  always_comb begin
    w_half   = r_pc[1] ? w_head.rdata[31:16] : w_head.rdata[15:0];
    w_comp   = !w_head.err && is_compressed(w_half[1:0]);
    w_span   = r_pc[1] && !w_comp && !w_head.err;
    w_valid  = (w_occ != '0) && (!w_span || (w_occ >= OCC_W'(2)));
    w_err    = w_head.err || (w_span && w_next.err);
    w_retire = !w_comp || r_pc[1];
    if (w_comp) begin
      w_instr = {16'h0000, w_half};
    end else if (r_pc[1]) begin
      w_instr = {w_next.rdata[15:0], w_half};
    end else begin
      w_instr = w_head.rdata;
    end
  end

  assign w_pop = w_valid && instr_ready_i && !redirect_i && w_retire;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc <= {PC_RESET[31:1], 1'b0};
    end else if (redirect_i) begin
      r_pc <= redirect_pc_i;
    end else if (w_valid && instr_ready_i) begin
      r_pc <= r_pc + (w_comp ? 32'd2 : 32'd4);
    end
  end

  assign instr_valid_o         = w_valid;
  assign instr_o               = w_valid ? w_instr : '0;
  assign instr_pc_o            = r_pc;
  assign instr_is_compressed_o = w_valid && w_comp;
  assign instr_err_o           = w_valid && w_err;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomized bench: memory slave and redirects drive the prefetcher, a
// monitor checks every accepted instruction against a program-image model.
module tb_instr_prefetch_buffer;

  localparam logic [31:0] PC_RST = 32'h0000_0100;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MAXO   = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_is_compressed_o;
  logic        instr_err_o;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(
    .PC_RESET        (PC_RST),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .instr_req_o           (instr_req_o),
    .instr_gnt_i           (instr_gnt_i),
    .instr_addr_o          (instr_addr_o),
    .instr_rvalid_i        (instr_rvalid_i),
    .instr_rdata_i         (instr_rdata_i),
    .instr_err_i           (instr_err_i),
    .redirect_i            (redirect_i),
    .redirect_pc_i         (redirect_pc_i),
    .instr_valid_o         (instr_valid_o),
    .instr_ready_i         (instr_ready_i),
    .instr_o               (instr_o),
    .instr_pc_o            (instr_pc_o),
    .instr_is_compressed_o (instr_is_compressed_o),
    .instr_err_o           (instr_err_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] gen_pc;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned p_gnt = 70, p_rv = 60, p_rdy = 75, p_redir = 0;
  bit          redir_req = 1'b0;
  bit          bp_en = 1'b0;
  int unsigned bp_grants = 0;
  bit          wd_en = 1'b0;
  int unsigned idle = 0;

  // Program image: pseudo-random words with ~half compressed halfwords.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] h;
    h = (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    h[1:0]   = h[20] ? 2'b11 : {1'b0, h[21]};
    h[17:16] = h[22] ? 2'b11 : {1'b0, h[23]};
    return h;
  endfunction

  function automatic logic err_at(input logic [31:0] a);
    return ((a >> 2) % 29) == 7;
  endfunction

  function automatic exp_t ref_instr(input logic [31:0] pc);
    logic [31:0] wa, w0, w1;
    logic [15:0] half;
    exp_t e;
    wa   = pc & ~32'h3;
    w0   = word_at(wa);
    half = pc[1] ? w0[31:16] : w0[15:0];
    e.pc = pc;
    if (err_at(wa)) begin
      e.err = 1'b1; e.comp = 1'b0; e.instr = '0;
    end else if (half[1:0] != 2'b11) begin
      e.err = 1'b0; e.comp = 1'b1; e.instr = {16'h0000, half};
    end else if (!pc[1]) begin
      e.err = 1'b0; e.comp = 1'b0; e.instr = w0;
    end else begin
      w1 = word_at(wa + 32'd4);
      e.err = err_at(wa + 32'd4); e.comp = 1'b0; e.instr = {w1[15:0], half};
    end
    return e;
  endfunction

  function automatic void extend(input int unsigned n);
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      e = ref_instr(gen_pc);
      exp_q.push_back(e);
      gen_pc = gen_pc + (e.comp ? 32'd2 : 32'd4);
    end
  endfunction

  function automatic void restart(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = {pc[31:1], 1'b0};
    extend(32);
  endfunction

  function automatic bit chance(input int unsigned p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Memory slave, decode ready and redirect source.
  initial begin
    logic [31:0] a, tgt;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0; instr_err_i = 0;
    redirect_i = 0; redirect_pc_i = 0; instr_ready_i = 0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        pend_q.delete();
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_err_i = 0; redirect_i = 0;
      end else begin
        if (pend_q.size() > 0 && chance(p_rv)) begin
          a = pend_q.pop_front();
          instr_rvalid_i = 1'b1;
          instr_rdata_i  = word_at(a);
          instr_err_i    = err_at(a);
        end else begin
          instr_rvalid_i = 1'b0;
          instr_rdata_i  = $urandom;
          instr_err_i    = 1'($urandom);
        end
        instr_gnt_i   = instr_req_o && chance(p_gnt);
        instr_ready_i = chance(p_rdy);
        if (redir_req || chance(p_redir)) begin
          tgt = 32'h1000 + (32'($urandom_range(2047, 0)) << 1);
          redirect_i    = 1'b1;
          redirect_pc_i = tgt;
          restart(tgt);
          bp_grants = 0;
          redir_req = 1'b0;
        end else begin
          redirect_i = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t        e;
    bit          prev_held;
    logic [31:0] prev_addr;
    bit          ok;
    prev_held = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_held = 1'b0;
      end else begin
        if (prev_held) chk("held_req", instr_req_o && instr_addr_o == prev_addr, instr_addr_o, prev_addr);
        prev_held = instr_req_o && !instr_gnt_i;
        prev_addr = instr_addr_o;
        if (instr_req_o && instr_gnt_i) begin
          chk("addr_align", instr_addr_o[1:0] == 2'b00, instr_addr_o, instr_addr_o & ~32'h3);
          pend_q.push_back(instr_addr_o);
          if (bp_en && !redirect_i) bp_grants++;
        end
        chk("outstanding_bound", pend_q.size() <= MAXO, pend_q.size(), MAXO);
        if (instr_valid_o && instr_ready_i && !redirect_i) begin
          idle = 0;
          if (exp_q.size() < 8) extend(32);
          e  = exp_q.pop_front();
          ok = instr_pc_o == e.pc && instr_err_o == e.err && instr_is_compressed_o == e.comp &&
               (e.err || instr_o == e.instr);
          n_vec++;
          if (!ok) begin
            n_bad++;
            $display("FAIL instr: actual pc=%h instr=%h c=%b e=%b required pc=%h instr=%h c=%b e=%b t=%0t",
                     instr_pc_o, instr_o, instr_is_compressed_o, instr_err_o,
                     e.pc, e.instr, e.comp, e.err, $time);
          end
        end else if (wd_en) begin
          idle++;
          if (idle == 400) chk("watchdog_no_progress", 1'b0, idle, 0);
        end
      end
    end
  end

  initial begin
    int unsigned tp;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req",   instr_req_o == 1'b0,           instr_req_o, 0);
    chk("rst_addr",  instr_addr_o == (PC_RST & ~32'h3), instr_addr_o, PC_RST & ~32'h3);
    chk("rst_valid", instr_valid_o == 1'b0,         instr_valid_o, 0);
    chk("rst_instr", instr_o == 32'h0,              instr_o, 0);
    chk("rst_pc",    instr_pc_o == PC_RST,          instr_pc_o, PC_RST);
    chk("rst_comp",  instr_is_compressed_o == 1'b0, instr_is_compressed_o, 0);
    chk("rst_err",   instr_err_o == 1'b0,           instr_err_o, 0);
    @(negedge clk);
    restart(PC_RST);
    rstn = 1'b1;
    @(posedge clk); #2;
    chk("req_after_reset", instr_req_o == 1'b1, instr_req_o, 1);
    chk("first_addr", instr_addr_o == PC_RST, instr_addr_o, PC_RST);

    wd_en = 1'b1;
    repeat (200) @(posedge clk);
    p_redir = 3;
    repeat (3000) @(posedge clk);

    // Zero-wait memory: one instruction per cycle once the pipe is primed.
    p_gnt = 100; p_rv = 100; p_rdy = 100; p_redir = 0;
    repeat (4) @(posedge clk);
    #3 redir_req = 1'b1;
    repeat (10) @(negedge clk);
    tp = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (instr_valid_o) tp++;
    end
    chk("throughput", tp == 32, tp, 32);

    // Decode stalled: exactly DEPTH new-stream words accepted, then no request.
    wd_en = 1'b0; p_rdy = 0; bp_en = 1'b1;
    repeat (3) @(posedge clk);
    #3 redir_req = 1'b1;
    repeat (25) @(negedge clk);
    chk("bp_grants", bp_grants == DEPTH, bp_grants, DEPTH);
    chk("bp_req_low", instr_req_o == 1'b0, instr_req_o, 0);
    chk("bp_valid", instr_valid_o == 1'b1, instr_valid_o, 1);
    bp_en = 1'b0;

    p_gnt = 70; p_rv = 60; p_rdy = 75; p_redir = 3; idle = 0; wd_en = 1'b1;
    repeat (500) @(posedge clk);

    // Asynchronous reset in the middle of traffic.
    wd_en = 1'b0;
    @(posedge clk); #2 rstn = 1'b0;
    #1;
    chk("midrst_valid", instr_valid_o == 1'b0, instr_valid_o, 0);
    chk("midrst_req",   instr_req_o == 1'b0,   instr_req_o, 0);
    chk("midrst_pc",    instr_pc_o == PC_RST,  instr_pc_o, PC_RST);
    repeat (3) @(posedge clk);
    @(negedge clk);
    restart(PC_RST);
    rstn = 1'b1;
    idle = 0; wd_en = 1'b1;
    repeat (1000) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
